// File: rtl/simon_display_mux_pkg.sv
// Shared constants, types and helpers for the Simon multiplexed 7-segment display driver.
// Segment patterns are ordered {g,f,e,d,c,b,a}, active-high.
package simon_display_mux_pkg;

  localparam logic [6:0] SEG_OFF  = 7'b0000000;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  localparam logic [6:0] SEG_FONT [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  typedef enum logic {
    CONV_IDLE,
    CONV_RUN
  } conv_state_e;

  function automatic int bcd_width(input int num_digits);
    return 4 * num_digits;
  endfunction

  // Non-decimal nibbles cannot come out of the converter but map to blank anyway.
  function automatic logic [6:0] seg_font(input logic [3:0] digit);
    logic [6:0] pattern;
    pattern = SEG_OFF;
    for (int i = 0; i < 10; i++) begin
      if (digit == 4'(i)) pattern = SEG_FONT[i];
    end
    return pattern;
  endfunction

endpackage

// File: rtl/simon_display_mux_if.sv
// Value-load handshake, display controls and pad-side outputs of the display driver.
// master = game FSM / pad mapping side, slave = the display driver.
interface simon_display_mux_if #(
  parameter int NUM_DIGITS  = 2,
  parameter int VALUE_WIDTH = 7
);

  logic [VALUE_WIDTH-1:0] value;
  logic                   value_valid;
  logic                   busy;
  logic                   overflow;
  logic                   seg_inv;
  logic                   blank_lz;
  logic                   blink_en;
  logic [6:0]             seg;
  logic [NUM_DIGITS-1:0]  dig;

  modport master (
    output value, value_valid, seg_inv, blank_lz, blink_en,
    input  busy, overflow, seg, dig
  );

  modport slave (
    input  value, value_valid, seg_inv, blank_lz, blink_en,
    output busy, overflow, seg, dig
  );

endinterface

// File: rtl/simon_display_mux_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/add-3 step per cycle, VALUE_WIDTH steps.
// done marks the last step; bcd/ovf carry that step's result so the caller can commit on the same edge.
module bin2bcd_seq
  import simon_display_mux_pkg::*;
#(
  parameter int VALUE_WIDTH = 7,
  parameter int NUM_DIGITS  = 2,
  localparam int BCD_W      = bcd_width(NUM_DIGITS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [VALUE_WIDTH-1:0] bin,
  output logic                   busy,
  output logic                   done,
  output logic [BCD_W-1:0]       bcd,
  output logic                   ovf
);

  localparam int CNT_W = $clog2(VALUE_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VALUE_WIDTH - 1);

  conv_state_e            state_q, state_d;
  logic [VALUE_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [BCD_W-1:0]       bcd_adj, bcd_step;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d, ovf_step;
  logic                   last_step;

  // A 1 leaving the top BCD bit means the value has crossed 10**NUM_DIGITS.
  always_comb begin : dabble_step
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[BCD_W-2:0], bin_q[VALUE_WIDTH-1]};
    ovf_step = ovf_q | bcd_adj[BCD_W-1];
  end

  assign last_step = (state_q == CONV_RUN) && (cnt_q == LAST_STEP);

  always_comb begin : conv_fsm
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      CONV_IDLE: begin
        if (start) begin
          state_d = CONV_RUN;
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      CONV_RUN: begin
        bin_d = bin_q << 1;
        bcd_d = bcd_step;
        ovf_d = ovf_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          state_d = CONV_IDLE;
          if (start) begin
            state_d = CONV_RUN;
            bin_d   = bin;
            bcd_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
      end
      default: state_d = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == CONV_RUN);
  assign done = last_step;
  assign bcd  = bcd_step;
  assign ovf  = ovf_step;

endmodule

// File: rtl/simon_display_mux.sv
// N-digit multiplexed 7-segment driver: sequential BCD conversion with a one-deep pending load,
// dead-time digit scan, leading-zero blanking, blink, overflow dashes and runtime polarity select.
module simon_display_mux
  import simon_display_mux_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int VALUE_WIDTH  = 7,
  parameter int REFRESH_DIV  = 1024,
  parameter int DEAD_CYCLES  = 8,
  parameter int BLINK_FRAMES = 32
) (
  input logic                clk,
  input logic                rst_n,
  simon_display_mux_if.slave bus
);

  localparam int BCD_W = bcd_width(NUM_DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic                   conv_start, conv_busy, conv_done, conv_ovf;
  logic [VALUE_WIDTH-1:0] conv_bin;
  logic [BCD_W-1:0]       conv_bcd;

  logic                   pend_valid_q, pend_valid_d;
  logic [VALUE_WIDTH-1:0] pend_value_q, pend_value_d;
  logic [BCD_W-1:0]       disp_bcd_q, disp_bcd_d;
  logic                   ovf_q, ovf_d;

  logic [PRE_W-1:0]       presc_q, presc_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FRM_W-1:0]       frame_q, frame_d;
  logic                   phase_q, phase_d;

  logic [6:0]             seg_q, seg_d;
  logic [NUM_DIGITS-1:0]  dig_q, dig_d;
  logic [3:0]             cur_digit;
  logic                   cur_blanked;
  logic                   upper_zero;
  logic [NUM_DIGITS-1:0]  blanked;

  bin2bcd_seq #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .NUM_DIGITS  (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  // A strobe on the commit cycle beats the pending value; either restarts the converter back-to-back.
  always_comb begin : load_ctrl
    conv_start   = 1'b0;
    conv_bin     = bus.value;
    pend_valid_d = pend_valid_q;
    pend_value_d = pend_value_q;
    disp_bcd_d   = disp_bcd_q;
    ovf_d        = ovf_q;
    if (!conv_busy) begin
      conv_start = bus.value_valid;
    end else if (conv_done) begin
      disp_bcd_d   = conv_bcd;
      ovf_d        = conv_ovf;
      pend_valid_d = 1'b0;
      if (bus.value_valid) begin
        conv_start = 1'b1;
      end else if (pend_valid_q) begin
        conv_start = 1'b1;
        conv_bin   = pend_value_q;
      end
    end else if (bus.value_valid) begin
      pend_valid_d = 1'b1;
      pend_value_d = bus.value;
    end
  end

  always_comb begin : scan_timing
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d = '0;
        if (frame_q == FRM_W'(BLINK_FRAMES - 1)) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + FRM_W'(1);
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Digit 0 is never blanked; overflow dashes override blanking.
  always_comb begin : digit_drive
    upper_zero  = 1'b1;
    blanked     = '0;
    cur_digit   = disp_bcd_q[3:0];
    cur_blanked = 1'b0;
    dig_d       = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (disp_bcd_q[4*i +: 4] == 4'd0);
      blanked[i] = bus.blank_lz & upper_zero & ~ovf_q;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit   = disp_bcd_q[4*i +: 4];
        cur_blanked = blanked[i];
      end
    end
    seg_d = ovf_q ? SEG_DASH : seg_font(cur_digit);
    if ((presc_q >= PRE_W'(DEAD_CYCLES)) && !cur_blanked && !(bus.blink_en && phase_q)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) dig_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_value_q <= '0;
      disp_bcd_q   <= '0;
      ovf_q        <= 1'b0;
      presc_q      <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      phase_q      <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_q        <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_value_q <= pend_value_d;
      disp_bcd_q   <= disp_bcd_d;
      ovf_q        <= ovf_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
    end
  end

  assign bus.busy     = conv_busy;
  assign bus.overflow = ovf_q;
  assign bus.seg      = seg_q ^ {7{bus.seg_inv}};
  assign bus.dig      = dig_q ^ {NUM_DIGITS{bus.seg_inv}};

endmodule
